// File: rtl/debug_capture_pkg.sv
// Shared types and trigger-mode encodings for the serial debug capture block.
package debug_capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } capture_state_t;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;
    localparam logic [1:0] TRIG_HIGH = 2'b11;

endpackage

// File: rtl/debug_word_fifo.sv
// Show-ahead word FIFO; a push into a full FIFO without a same-cycle pop is dropped
// and reported on the drop strobe.
module debug_word_fifo #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_capture.sv
// Host-side receiver for the tag's serial debug stream: triggered MSB-first word
// capture into a small FIFO, plus a saturating rising-edge counter.
module debug_capture
    import debug_capture_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              debug_clk,
    input  logic              reset,
    input  logic              debug_in,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [3:0]        num_words,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  edge_count
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    capture_state_t    state;
    logic [WORD_W-2:0] shift;
    logic [BW-1:0]     bit_cnt;
    logic [4:0]        words_left;
    logic [1:0]        mode;
    logic              in_d;

    logic              rise;
    logic              fall;
    logic              trig_hit;
    logic              arm_ok;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              fifo_empty;
    logic              fifo_drop;

    assign rise      = debug_in & ~in_d;
    assign fall      = ~debug_in & in_d;
    assign arm_ok    = arm & ((state == IDLE) | (state == DONE));
    assign push      = (state == CAPTURE) & (bit_cnt == LAST_BIT);
    assign push_data = {shift, debug_in};

    always_comb begin
        trig_hit = 1'b0;
        case (mode)
            TRIG_IMM:  trig_hit = 1'b1;
            TRIG_RISE: trig_hit = rise;
            TRIG_FALL: trig_hit = fall;
            TRIG_HIGH: trig_hit = debug_in;
            default:   trig_hit = 1'b0;
        endcase
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            in_d <= 1'b0;
        end else begin
            in_d <= debug_in;
        end
    end

    // The trigger cycle's own sample becomes the MSB of the first word.
    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            mode       <= TRIG_IMM;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        mode       <= trig_mode;
                        words_left <= (num_words == 4'd0) ? 5'd16 : {1'b0, num_words};
                        shift      <= '0;
                        bit_cnt    <= '0;
                        state      <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        shift   <= {{(WORD_W-2){1'b0}}, debug_in};
                        bit_cnt <= BW'(1);
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    shift <= push_data[WORD_W-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt    <= '0;
                        words_left <= words_left - 5'd1;
                        if (words_left == 5'd1) begin
                            state <= DONE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (arm_ok) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            edge_count <= '0;
        end else if (clear_count) begin
            edge_count <= '0;
        end else if (rise && (edge_count != '1)) begin
            edge_count <= edge_count + 1'b1;
        end
    end

    debug_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (debug_clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign rd_valid = ~fifo_empty;
    assign busy     = (state == WAIT_TRIG) | (state == CAPTURE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_debug_capture.sv
// Randomized and directed bench for debug_capture against a bit-stream level model.
module tb_debug_capture;
    import debug_capture_pkg::*;

    localparam int WORD_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 12;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              debug_clk;
    logic              reset;
    logic              debug_in;
    logic              arm;
    logic [1:0]        trig_mode;
    logic [3:0]        num_words;
    logic              rd_en;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              fifo_full;
    logic              overflow;
    logic              busy;
    logic              done;
    logic              clear_count;
    logic [CNT_W-1:0]  edge_count;

    int compared   = 0;
    int mismatched = 0;

    bit          stimBits[$];
    bit          stimRd[$];
    logic [15:0] modelQ[$];
    bit          modelOvf;
    int          modelCnt;
    bit          modelPrev;
    int          probeIdx = -1;

    debug_capture #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .debug_clk   (debug_clk),
        .reset       (reset),
        .debug_in    (debug_in),
        .arm         (arm),
        .trig_mode   (trig_mode),
        .num_words   (num_words),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done),
        .clear_count (clear_count),
        .edge_count  (edge_count)
    );

    initial debug_clk = 1'b0;
    always #5 debug_clk = ~debug_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge counter model advances with each clock edge, then inputs are sampled 1ns later.
    task automatic tick();
        if (reset) begin
            modelCnt  = 0;
            modelPrev = 1'b0;
        end else begin
            if (clear_count) modelCnt = 0;
            else if (debug_in && !modelPrev && modelCnt != CNT_MAX) modelCnt++;
            modelPrev = debug_in;
        end
        @(posedge debug_clk);
        #1;
    endtask

    task automatic clearStim();
        stimBits.delete();
        stimRd.delete();
    endtask

    task automatic addBit(input bit b);
        stimBits.push_back(b);
        stimRd.push_back(1'b0);
    endtask

    task automatic addWord(input logic [15:0] w);
        for (int j = 15; j >= 0; j--) addBit(w[j]);
    endtask

    function automatic int findTrig(input logic [1:0] mode, input bit x0);
        for (int i = 0; i < stimBits.size(); i++) begin
            bit cur;
            bit prev;
            cur  = stimBits[i];
            prev = (i == 0) ? x0 : stimBits[i-1];
            case (mode)
                TRIG_IMM:  return i;
                TRIG_RISE: if (cur && !prev) return i;
                TRIG_FALL: if (!cur && prev) return i;
                default:   if (cur) return i;
            endcase
        end
        return -1;
    endfunction

    // Arm, then play stimBits/stimRd one bit per cycle while the model slices words.
    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] nw, input bit x0);
        int nEff;
        int t;
        logic [15:0] w;
        nEff = (nw == 4'd0) ? 16 : int'(nw);
        trig_mode = mode;
        num_words = nw;
        debug_in  = x0;
        rd_en     = 1'b0;
        arm       = 1'b1;
        tick();
        arm      = 1'b0;
        modelOvf = 1'b0;
        t = findTrig(mode, x0);
        for (int i = 0; i < stimBits.size(); i++) begin
            bit pushNow;
            bit popNow;
            debug_in = stimBits[i];
            rd_en    = stimRd[i];
            pushNow  = (t >= 0) && (i >= t) && (i - t < 16 * nEff) && ((i - t) % 16 == 15);
            popNow   = stimRd[i] && (modelQ.size() > 0);
            w = '0;
            if (pushNow) begin
                for (int j = i - 15; j <= i; j++) w = (w << 1) | 16'(stimBits[j]);
            end
            if (pushNow && modelQ.size() == FIFO_DEPTH && !popNow) begin
                modelOvf = 1'b1;
            end else begin
                if (popNow) void'(modelQ.pop_front());
                if (pushNow) modelQ.push_back(w);
            end
            tick();
            if (i == probeIdx) checkOutput("latency_early", 32'(rd_valid), 0);
        end
        rd_en = 1'b0;
    endtask

    task automatic drainAndCheck(input string tag);
        checkOutput({tag, "_full"}, 32'(fifo_full), 32'(modelQ.size() == FIFO_DEPTH));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(modelOvf));
        checkOutput({tag, "_cnt"}, 32'(edge_count), 32'(modelCnt));
        while (modelQ.size() > 0) begin
            checkOutput({tag, "_valid"}, 32'(rd_valid), 1);
            checkOutput({tag, "_data"}, 32'(rd_data), 32'(modelQ[0]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(modelQ.pop_front());
        end
        checkOutput({tag, "_empty"}, 32'(rd_valid), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_data"}, 32'(rd_data), 0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
        checkOutput({tag, "_full"}, 32'(fifo_full), 0);
        checkOutput({tag, "_ovf"}, 32'(overflow), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_cnt"}, 32'(edge_count), 0);
    endtask

    initial begin
        int nEff;
        int t;
        int total;
        logic [1:0] mode;
        logic [3:0] nw;
        bit x0;

        reset       = 1'b1;
        debug_in    = 1'b0;
        arm         = 1'b0;
        trig_mode   = 2'b00;
        num_words   = 4'd0;
        rd_en       = 1'b0;
        clear_count = 1'b0;
        modelCnt    = 0;
        modelPrev   = 1'b0;
        modelOvf    = 1'b0;
        #3;
        checkAllZero("reset");
        tick();
        tick();
        reset = 1'b0;

        // Immediate trigger, single word, latency probe on the cycle before the push.
        clearStim();
        addWord(16'hA5C3);
        probeIdx = 14;
        applyStimulus(TRIG_IMM, 4'd1, 1'b0);
        probeIdx = -1;
        checkOutput("imm_valid", 32'(rd_valid), 1);
        checkOutput("imm_data", 32'(rd_data), 32'h0000A5C3);
        checkOutput("imm_done", 32'(done), 1);
        checkOutput("imm_busy", 32'(busy), 0);
        drainAndCheck("imm");

        // Rising trigger after a low preamble.
        clearStim();
        for (int i = 0; i < 10; i++) addBit(1'b0);
        addWord(16'h8001);
        addWord(16'hFFFE);
        applyStimulus(TRIG_RISE, 4'd2, 1'b0);
        checkOutput("rise_w0", 32'(rd_data), 32'h00008001);
        drainAndCheck("rise");

        // Overflow: six words into four slots, no reads.
        clearStim();
        for (int k = 1; k <= 6; k++) addWord(16'(k));
        applyStimulus(TRIG_IMM, 4'd6, 1'b0);
        checkOutput("ovf_full", 32'(fifo_full), 1);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        checkOutput("ovf_head", 32'(rd_data), 1);

        // Re-arm clears overflow but keeps the buffered words.
        trig_mode = TRIG_HIGH;
        num_words = 4'd1;
        debug_in  = 1'b0;
        arm       = 1'b1;
        tick();
        arm      = 1'b0;
        modelOvf = 1'b0;
        checkOutput("rearm_ovf", 32'(overflow), 0);
        checkOutput("rearm_head", 32'(rd_data), 1);
        checkOutput("rearm_busy", 32'(busy), 1);
        checkOutput("rearm_full", 32'(fifo_full), 1);

        // Push and pop on the same cycle while full; the arm inside is ignored in WAIT_TRIG.
        clearStim();
        for (int i = 0; i < 3; i++) addBit(1'b0);
        addWord(16'h8007);
        stimRd[3 + 15] = 1'b1;
        applyStimulus(TRIG_HIGH, 4'd1, 1'b0);
        checkOutput("pp_ovf", 32'(overflow), 0);
        checkOutput("pp_head", 32'(rd_data), 2);
        checkOutput("pp_full", 32'(fifo_full), 1);
        checkOutput("pp_done", 32'(done), 1);
        drainAndCheck("pp");

        // Edge counter saturation, then clear-over-increment.
        for (int i = 0; i < 4500; i++) begin
            debug_in = 1'b1;
            tick();
            debug_in = 1'b0;
            tick();
        end
        checkOutput("cnt_sat", 32'(edge_count), CNT_MAX);
        checkOutput("cnt_model", 32'(edge_count), 32'(modelCnt));
        debug_in    = 1'b1;
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        checkOutput("cnt_clear", 32'(edge_count), 0);
        debug_in = 1'b0;
        tick();
        debug_in = 1'b1;
        tick();
        checkOutput("cnt_after_clear", 32'(edge_count), 1);
        debug_in = 1'b0;
        tick();

        // Reset seven bits into the third word.
        clearStim();
        addWord(16'hAAAA);
        addWord(16'h5555);
        addBit(1'b1); addBit(1'b0); addBit(1'b1); addBit(1'b1);
        addBit(1'b0); addBit(1'b0); addBit(1'b1);
        applyStimulus(TRIG_IMM, 4'd3, 1'b0);
        checkOutput("mid_busy", 32'(busy), 1);
        checkOutput("mid_valid", 32'(rd_valid), 1);
        reset = 1'b1;
        #2;
        modelQ.delete();
        modelOvf  = 1'b0;
        modelCnt  = 0;
        modelPrev = 1'b0;
        checkAllZero("midreset");
        tick();
        tick();
        reset = 1'b0;
        clearStim();
        addWord(16'h1234);
        applyStimulus(TRIG_IMM, 4'd1, 1'b0);
        checkOutput("post_reset_data", 32'(rd_data), 32'h00001234);
        drainAndCheck("postreset");

        // Randomized captures with random reads interleaved.
        for (int iter = 0; iter < 25; iter++) begin
            mode = 2'($urandom_range(0, 3));
            nw   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
            x0   = 1'($urandom_range(0, 1));
            nEff = (nw == 4'd0) ? 16 : int'(nw);
            do begin
                clearStim();
                total = int'($urandom_range(0, 12)) + 16 * nEff + 4;
                for (int i = 0; i < total; i++) begin
                    stimBits.push_back(1'($urandom_range(0, 1)));
                    stimRd.push_back($urandom_range(0, 3) == 0);
                end
                t = findTrig(mode, x0);
            end while (t < 0 || t + 16 * nEff > total);
            applyStimulus(mode, nw, x0);
            checkOutput("rnd_done", 32'(done), 1);
            checkOutput("rnd_busy", 32'(busy), 0);
            drainAndCheck("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
